// File: rtl/hdmi_pattern_engine_pkg.sv
// Shared TMDS symbols, pattern-mode encoding and 640x480 default timing for the pattern engine.
// Pure definitions; no logic, no latency, no flow control.
package hdmi_pkg;

    localparam logic [9:0] SYM_WHITE = 10'b1011110000;
    localparam logic [9:0] SYM_BLACK = 10'b0111110000;
    localparam logic [9:0] SYM_CTL00 = 10'b1101010100;
    localparam logic [9:0] SYM_CTL01 = 10'b0010101011;
    localparam logic [9:0] SYM_CTL10 = 10'b0101010100;
    localparam logic [9:0] SYM_CTL11 = 10'b1010101011;

    typedef enum logic [2:0] {
        MODE_OR   = 3'd0,
        MODE_XOR  = 3'd1,
        MODE_AND  = 3'd2,
        MODE_ANDN = 3'd3,
        MODE_XNOR = 3'd4
    } mode_e;

    localparam int MODE_COUNT = 5;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Unreachable encodings 5..7 also fall back to mode 0.
    function automatic logic [2:0] next_mode(input logic [2:0] m);
        return (m >= 3'(MODE_COUNT - 1)) ? 3'd0 : m + 3'd1;
    endfunction

    function automatic logic [9:0] ctl_symbol(input logic vs, input logic hs);
        case ({vs, hs})
            2'b00:   return SYM_CTL00;
            2'b01:   return SYM_CTL01;
            2'b10:   return SYM_CTL10;
            default: return SYM_CTL11;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_pattern_engine_key_debounce.sv
// Two-flop synchroniser plus per-bit debounce: a bit follows its input after DEB_CYCLES stable cycles.
// Latency 2 + DEB_CYCLES cycles from input change to output change; no flow control.
module key_debounce #(
    parameter int WIDTH      = 1,
    parameter int DEB_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] deb_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [WIDTH-1:0]         meta_q;
    logic [WIDTH-1:0]         sync_q;
    logic [WIDTH-1:0]         deb_q;
    logic [WIDTH-1:0]         deb_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q;
    logic [WIDTH-1:0][CW-1:0] cnt_d;

    // Any cycle where the synchronised bit agrees with the accepted value restarts its count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                deb_d[i] = sync_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            deb_q  <= '0;
            cnt_q  <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/hdmi_pattern_engine.sv
// Raster timing, coordinate pattern vs. frame-latched key mask, TMDS restricted-set symbol output.
// All outputs registered one cycle behind the raster counters; free-running, no backpressure.
module hdmi_pattern_engine
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int KEY_W       = 9,
    parameter int DEB_CYCLES  = 250000,
    parameter int AUTO_FRAMES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] key_raw,
    input  logic             mode_btn,
    output logic [9:0]       c0_symbol,
    output logic [9:0]       c1_symbol,
    output logic [9:0]       c2_symbol,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             frame_start,
    output logic [2:0]       mode
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_ACT0  = H_SYNC + H_BP;
    localparam int H_ACT1  = H_ACT0 + H_ACTIVE;
    localparam int V_ACT0  = V_SYNC + V_BP;
    localparam int V_ACT1  = V_ACT0 + V_ACTIVE;
    // Counters are at least KEY_W wide so the pattern can always slice [KEY_W-1:0].
    localparam int CW      = max2(max2($clog2(H_TOTAL), $clog2(V_TOTAL)), KEY_W);
    localparam int FW      = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam bit AUTO_EN = (AUTO_FRAMES != 0);

    logic [CW-1:0]    hc_q;
    logic [CW-1:0]    hc_d;
    logic [CW-1:0]    vc_q;
    logic [CW-1:0]    vc_d;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] key_d;
    logic [KEY_W-1:0] key_deb;
    logic [2:0]       mode_q;
    logic [2:0]       mode_d;
    logic             pend_q;
    logic             pend_d;
    logic [FW-1:0]    fc_q;
    logic [FW-1:0]    fc_d;
    logic [0:0]       btn_deb;
    logic             btn_prev_q;

    logic             h_last;
    logic             v_last;
    logic             sof;
    logic             eof;
    logic             btn_rise;
    logic             auto_evt;

    logic             hs_c;
    logic             vs_c;
    logic             act_c;
    logic [KEY_W-1:0] hk;
    logic [KEY_W-1:0] vk;
    logic [KEY_W-1:0] pat_c;
    logic [9:0]       c0_c;
    logic [9:0]       c12_c;

    logic [9:0]       c0_q;
    logic [9:0]       c12_q;
    logic             hs_q;
    logic             vs_q;
    logic             act_q;
    logic             fs_q;

    key_debounce #(
        .WIDTH      (KEY_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_deb (
        .clk   (clk),
        .reset (reset),
        .raw_i (key_raw),
        .deb_o (key_deb)
    );

    key_debounce #(
        .WIDTH      (1),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_deb (
        .clk   (clk),
        .reset (reset),
        .raw_i (mode_btn),
        .deb_o (btn_deb)
    );

    assign h_last   = (hc_q == CW'(H_TOTAL - 1));
    assign v_last   = (vc_q == CW'(V_TOTAL - 1));
    assign sof      = (hc_q == '0) && (vc_q == '0);
    assign eof      = h_last && v_last;
    assign btn_rise = btn_deb[0] && !btn_prev_q;
    assign auto_evt = AUTO_EN && eof && (fc_q == FW'(AUTO_FRAMES - 1));

    // Raster, frame-synchronous key/mode update and pending-advance bookkeeping.
    always_comb begin
        hc_d   = hc_q + CW'(1);
        vc_d   = vc_q;
        key_d  = key_q;
        mode_d = mode_q;
        pend_d = pend_q || btn_rise || auto_evt;
        fc_d   = fc_q;
        if (h_last) begin
            hc_d = '0;
            vc_d = v_last ? '0 : vc_q + CW'(1);
        end
        if (AUTO_EN && eof) begin
            fc_d = auto_evt ? '0 : fc_q + FW'(1);
        end
        // Events arriving in the start-of-frame cycle itself wait for the next frame.
        if (sof) begin
            key_d  = key_deb;
            mode_d = pend_q ? next_mode(mode_q) : mode_q;
            pend_d = btn_rise || auto_evt;
        end
    end

    always_comb begin
        hs_c  = (hc_q < CW'(H_SYNC));
        vs_c  = (vc_q < CW'(V_SYNC));
        act_c = (hc_q >= CW'(H_ACT0)) && (hc_q < CW'(H_ACT1)) &&
                (vc_q >= CW'(V_ACT0)) && (vc_q < CW'(V_ACT1));
        hk    = hc_q[KEY_W-1:0];
        vk    = vc_q[KEY_W-1:0];
        case (mode_q)
            MODE_XOR:  pat_c = hk ^ vk;
            MODE_AND:  pat_c = hk & vk;
            MODE_ANDN: pat_c = hk & ~vk;
            MODE_XNOR: pat_c = ~(hk ^ vk);
            default:   pat_c = hk | vk;
        endcase
        if (act_c) begin
            c12_c = (pat_c == key_q) ? SYM_WHITE : SYM_BLACK;
            c0_c  = c12_c;
        end else begin
            c12_c = SYM_CTL00;
            c0_c  = ctl_symbol(vs_c, hs_c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hc_q       <= '0;
            vc_q       <= '0;
            key_q      <= '0;
            mode_q     <= '0;
            pend_q     <= 1'b0;
            fc_q       <= '0;
            btn_prev_q <= 1'b0;
            c0_q       <= SYM_CTL00;
            c12_q      <= SYM_CTL00;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            act_q      <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            hc_q       <= hc_d;
            vc_q       <= vc_d;
            key_q      <= key_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            fc_q       <= fc_d;
            btn_prev_q <= btn_deb[0];
            c0_q       <= c0_c;
            c12_q      <= c12_c;
            hs_q       <= hs_c;
            vs_q       <= vs_c;
            act_q      <= act_c;
            fs_q       <= sof;
        end
    end

    assign c0_symbol   = c0_q;
    assign c1_symbol   = c12_q;
    assign c2_symbol   = c12_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign active      = act_q;
    assign frame_start = fs_q;
    assign mode        = mode_q;

endmodule

// File: doc/hdmi_pattern_engine.md
Name: hdmi_pattern_engine

Overview:
Parametrised pixel-clock-domain video source. Generates VGA/DVI raster timing, computes a bitwise coordinate pattern with a selectable operator, and compares it against a debounced key mask. It emits restricted-set TMDS 10-bit symbols for channels 0/1/2 (white, black, or control).
Sits between the PLL-derived pixel clock and the DDR serialiser. It adds what the first generation lacked: runtime mode selection, key debounce, frame-synchronous updates, auto-cycle, and configurable timing.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
KEY_W, 9, key mask width; compared against pattern bits [KEY_W-1:0]
DEB_CYCLES, 250000, consecutive stable cycles before a key/button change is accepted
AUTO_FRAMES, 0, frames per automatic mode advance; 0 disables auto-cycle

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
key_raw  in  KEY_W  asynchronous key switches
mode_btn  in  1  asynchronous mode-advance button
c0_symbol  out  10  blue TMDS symbol, carries {vsync,hsync} control during blanking
c1_symbol  out  10  green TMDS symbol
c2_symbol  out  10  red TMDS symbol
hsync  out  1  active-high horizontal sync
vsync  out  1  active-high vertical sync
active  out  1  pixel in visible region
frame_start  out  1  one-cycle pulse at hc=0, vc=0
mode  out  3  currently applied pattern mode

Behaviour:
- Raster counters:
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise.
  - hc counts 0..H_TOTAL-1 and wraps to 0; at that wrap vc increments, wrapping from V_TOTAL-1 to 0. No extra column or line.
  - hsync when hc < H_SYNC; vsync when vc < V_SYNC.
  - active when H_SYNC+H_BP <= hc < H_SYNC+H_BP+H_ACTIVE, and the same rule holds for vc.
- Output timing:
  - All outputs are registered and reflect the counter values of the previous cycle (latency 1).
  - hsync, vsync, active and all symbols stay mutually aligned.
- Key path:
  - 2-flop synchroniser per bit, then per-bit debounce counter.
  - A debounced bit changes only after the synchronised input differs from it for DEB_CYCLES consecutive cycles; any bounce restarts that bit's count.
  - key_q (applied mask) loads the debounced vector only in the cycle where hc=0 and vc=0. There is no tearing mid-frame.
- Mode path:
  - mode_btn is synchronised and debounced identically.
  - A rising edge of the debounced button sets pend.
  - If AUTO_FRAMES != 0, a frame counter reaching AUTO_FRAMES-1 at end of frame also sets pend.
  - pend applies at the next frame start: mode advances 0→1→2→3→4→0, then pend clears.
  - A button edge and an auto event in the same frame advance mode by one only.
- Pattern operators, applied to hc[KEY_W-1:0] and vc[KEY_W-1:0]:
  - mode 0: OR
  - mode 1: XOR
  - mode 2: AND
  - mode 3: hc & ~vc
  - mode 4: XNOR
  - modes 5–7 are unreachable and decode as OR.
- Symbol selection:
  - active and pattern == key_q: all channels 1011110000 (white).
  - active, otherwise: all channels 0111110000 (black).
  - blanking: c1 = c2 = 1101010100; c0 from {vsync,hsync}:
    - 00 → 1101010100
    - 01 → 0010101011
    - 10 → 0101010100
    - 11 → 1010101011
- Reset:
  - hc, vc, key_q, mode, pend, frame counter and debounce state clear to 0.
  - Outputs clear to: all symbols 1101010100, hsync=vsync=active=frame_start=0, mode=0.
  - Reset asserted mid-frame overrides everything on the next edge.
  - After release, the first output cycle reflects hc=0, vc=0.

Decomposition:
- Package hdmi_pkg holds:
  - the TMDS constants SYM_WHITE, SYM_BLACK, SYM_CTL00/01/10/11;
  - the mode enum (MODE_OR, MODE_XOR, MODE_AND, MODE_ANDN, MODE_XNOR) with MODE_COUNT=5;
  - the 640x480 default timing constants.
- Sub-module key_debounce (parameters WIDTH, DEB_CYCLES) implements synchroniser plus debounce. It is instantiated once for key_raw and once for mode_btn.

Test Plan:
- Reset release, defaults: exactly 800 cycles between hsync rises and 420000 between frame_start pulses. hsync high for 96 cycles; active first high at output of hc=144, vc=35; last active at hc=783, vc=514.
- Mode 0, key_raw=9'h100 held past debounce and one frame_start: pixel at hc=256, vc=256 → white; hc=257, vc=256 → black.
- mode_btn pulsed for 10 cycles (< DEB_CYCLES=16 in bench) → mode stays 0. Held 20 cycles mid-frame → mode=1 only at the next frame_start.
- key_raw changed mid-frame → key_q and the white/black decision remain unchanged until the next frame_start.
- AUTO_FRAMES=2, button pressed in the same frame as the auto event → mode advances 0→1 (not 2). Cycling five advances returns mode to 0.
- Blanking symbols: at hc=0, vc=0 → c0=1010101011; hc=100, vc=0 → 0101010100; hc=0, vc=10 → 0010101011; hc=100, vc=10 → 1101010100. Reset asserted at hc=500, vc=300 → next cycle all symbols 1101010100, mode=0.
